// File: rtl/ddr2_read_dqs_responder.sv
// Memory-side DDR2 read responder: queues decoded READs and, CAS_LATENCY cycles later,
// drives preamble, a BURST_LEN beat burst with toggling DQS, and a postamble.
module ddr2_read_dqs_responder #(
  parameter int CAS_LATENCY = 4,
  parameter int BURST_LEN   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke_pad,
  input  logic                  csbar_pad,
  input  logic                  rasbar_pad,
  input  logic                  casbar_pad,
  input  logic                  webar_pad,
  input  logic [1:0]            ba_pad,
  input  logic [12:0]           addr_pad,
  output logic [DATA_WIDTH-1:0] dq_out,
  output logic                  dq_oe,
  output logic [1:0]            dqs_out,
  output logic                  dqs_oe,
  output logic                  burst_active,
  output logic                  overflow_err,
  output logic                  collision_err,
  output logic [15:0]           rd_count
);

  localparam int PW = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam int BW = $clog2(BURST_LEN);
  localparam int SW = (DATA_WIDTH > 12) ? DATA_WIDTH : 12;
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_PENDING - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(MAX_PENDING);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
  localparam logic [15:0]   CL16      = 16'(CAS_LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_BURST, S_POST} state_t;

  state_t state, state_n;

  logic [1:0]  q_ba  [MAX_PENDING];
  logic [9:0]  q_col [MAX_PENDING];
  logic [15:0] q_due [MAX_PENDING];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   cyc;

  logic [BW-1:0] beat, beat_n;
  logic [11:0]   act_addr, act_addr_n;

  logic is_read, full, push, pop, collide, rd_inc;
  logic head_valid, due_now, due_next, due_late, last_beat;
  logic [15:0] head_diff;

  logic [DATA_WIDTH-1:0] dq_n;
  logic [SW-1:0]         dq_sum;
  logic dq_oe_n, dqs_n, dqs_oe_n, active_n;
  logic unused_addr_hi;

  assign unused_addr_hi = ^addr_pad[12:10];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign is_read    = cke_pad & ~csbar_pad & rasbar_pad & ~casbar_pad & webar_pad;
  assign full       = (count == CNT_FULL);
  assign push       = is_read & ~full;
  assign head_valid = (count != '0);

  // Wrap-safe: distance from now to the head's first beat, read as a signed 16-bit value.
  assign head_diff  = q_due[rd_ptr] - cyc;
  assign due_now    = head_valid && (head_diff == 16'd0);
  assign due_next   = head_valid && (head_diff == 16'd1);
  assign due_late   = head_valid && head_diff[15];
  assign last_beat  = (beat == BEAT_LAST);

  always_comb begin
    state_n    = state;
    beat_n     = beat;
    act_addr_n = act_addr;
    pop        = 1'b0;
    collide    = 1'b0;
    case (state)
      S_IDLE: begin
        if (due_next) begin
          state_n = S_PRE;
        end else if (due_now || due_late) begin
          pop     = 1'b1;
          collide = 1'b1;
        end
      end
      S_PRE: begin
        if (head_valid) begin
          pop        = 1'b1;
          state_n    = S_BURST;
          beat_n     = '0;
          act_addr_n = {q_ba[rd_ptr], q_col[rd_ptr]};
        end else begin
          state_n = S_IDLE;
        end
      end
      S_BURST: begin
        if (last_beat) begin
          if (due_now) begin
            pop        = 1'b1;
            beat_n     = '0;
            act_addr_n = {q_ba[rd_ptr], q_col[rd_ptr]};
          end else begin
            // A head due one cycle later turns the postamble into its preamble.
            state_n = S_POST;
            if (due_late) begin
              pop     = 1'b1;
              collide = 1'b1;
            end
          end
        end else begin
          beat_n = beat + 1'b1;
          if (due_now || due_late) begin
            pop     = 1'b1;
            collide = 1'b1;
          end
        end
      end
      S_POST: begin
        if (due_now) begin
          pop        = 1'b1;
          state_n    = S_BURST;
          beat_n     = '0;
          act_addr_n = {q_ba[rd_ptr], q_col[rd_ptr]};
        end else if (due_next) begin
          state_n = S_PRE;
        end else begin
          state_n = S_IDLE;
          if (due_late) begin
            pop     = 1'b1;
            collide = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    dq_n     = '0;
    dq_sum   = '0;
    dq_oe_n  = 1'b0;
    dqs_n    = 1'b0;
    dqs_oe_n = 1'b0;
    active_n = 1'b0;
    case (state_n)
      S_PRE, S_POST: dqs_oe_n = 1'b1;
      S_BURST: begin
        dq_oe_n  = 1'b1;
        dqs_oe_n = 1'b1;
        active_n = 1'b1;
        dqs_n    = ~beat_n[0];
        dq_sum   = SW'(act_addr_n) + SW'(beat_n);
        dq_n     = dq_sum[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign rd_inc = (state_n == S_BURST) && (beat_n == BEAT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      beat          <= '0;
      act_addr      <= '0;
      cyc           <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      dq_out        <= '0;
      dq_oe         <= 1'b0;
      dqs_out       <= '0;
      dqs_oe        <= 1'b0;
      burst_active  <= 1'b0;
      overflow_err  <= 1'b0;
      collision_err <= 1'b0;
      rd_count      <= '0;
    end else begin
      state        <= state_n;
      beat         <= beat_n;
      act_addr     <= act_addr_n;
      cyc          <= cyc + 16'd1;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count        <= count + CW'(push) - CW'(pop);
      dq_out       <= dq_n;
      dq_oe        <= dq_oe_n;
      dqs_out      <= {2{dqs_n}};
      dqs_oe       <= dqs_oe_n;
      burst_active <= active_n;
      if (is_read && full) overflow_err <= 1'b1;
      if (collide) collision_err <= 1'b1;
      if (rd_inc) rd_count <= rd_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_ba[wr_ptr]  <= ba_pad;
      q_col[wr_ptr] <= addr_pad[9:0];
      q_due[wr_ptr] <= cyc + CL16;
    end
  end

endmodule
